// File: rtl/dem_split_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dem_split_checker: rebuilds x and s from a DEM tree split pair, tracks   |
// | the shaping accumulator and flags parity/bound (and optional PN) errors. |
// | Optional: DEM_PN_CHECK_EN enables the dither-sign check (err_pn_o).      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dem_split_checker #(
   parameter int WIDTH     = 5,
   parameter int ACC_LIMIT = 1,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 valid_i,
   input  logic [WIDTH-1:0]     x_out1_i,
   input  logic [WIDTH-1:0]     x_out2_i,
   input  logic                 pn_seq_i,
   input  logic                 clear_i,
   output logic                 valid_o,
   output logic [WIDTH:0]       x_rec_o,
   output logic [WIDTH:0]       s_rec_o,
   output logic [WIDTH+1:0]     acc_o,
   output logic                 err_parity_o,
   output logic                 err_bound_o,
   output logic                 err_pn_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o
);

   localparam logic signed [WIDTH+2:0] C_LIM_POS = (WIDTH+3)'(ACC_LIMIT);
   localparam logic signed [WIDTH+2:0] C_LIM_NEG = -C_LIM_POS;
   localparam logic signed [WIDTH:0]   C_S_ONE   = (WIDTH+1)'(1);
   localparam logic signed [WIDTH:0]   C_S_MONE  = -C_S_ONE;

   logic                        valid_q, valid_d;
   logic [WIDTH:0]              x_rec_q, x_rec_d;
   logic [WIDTH:0]              s_rec_q, s_rec_d;
   logic [WIDTH+1:0]            acc_q, acc_d;
   logic                        err_par_q, err_par_d;
   logic                        err_bnd_q, err_bnd_d;
   logic                        err_pn_q, err_pn_d;
   logic [ERR_CNT_W-1:0]        cnt_q, cnt_d;

   logic [WIDTH:0]              x_rec_w;
   logic signed [WIDTH:0]       s_rec_w;
   logic signed [WIDTH+2:0]     acc_next_w;
   logic signed [WIDTH+2:0]     acc_clamp_w;
   logic                        par_viol_w, bnd_viol_w, pn_viol_w;

   assign x_rec_w    = {1'b0, x_out1_i} + {1'b0, x_out2_i};
   assign s_rec_w    = $signed({1'b0, x_out1_i}) - $signed({1'b0, x_out2_i});
   // Accumulator stays within +/-ACC_LIMIT, so one guard bit covers acc + s.
   assign acc_next_w = $signed({acc_q[WIDTH+1], acc_q}) + $signed({{2{s_rec_w[WIDTH]}}, s_rec_w});

   assign par_viol_w = x_rec_w[0] ? !((s_rec_w == C_S_ONE) || (s_rec_w == C_S_MONE))
                                  : (s_rec_w != '0);
   assign bnd_viol_w = (acc_next_w > C_LIM_POS) || (acc_next_w < C_LIM_NEG);

   always_comb begin
      acc_clamp_w = acc_next_w;
      if (acc_next_w > C_LIM_POS) begin
         acc_clamp_w = C_LIM_POS;
      end else if (acc_next_w < C_LIM_NEG) begin
         acc_clamp_w = C_LIM_NEG;
      end
   end

`ifdef DEM_PN_CHECK_EN
   // Dither decides the sign only when the accumulator is balanced.
   assign pn_viol_w = x_rec_w[0] && (acc_q == '0) && (s_rec_w[WIDTH] == pn_seq_i);
`else
   logic unused_pn_w;
   assign unused_pn_w = pn_seq_i;
   assign pn_viol_w   = 1'b0;
`endif

   always_comb begin
      valid_d   = 1'b0;
      x_rec_d   = x_rec_q;
      s_rec_d   = s_rec_q;
      acc_d     = acc_q;
      err_par_d = err_par_q;
      err_bnd_d = err_bnd_q;
      err_pn_d  = err_pn_q;
      cnt_d     = cnt_q;
      if (clear_i) begin
         acc_d     = '0;
         err_par_d = 1'b0;
         err_bnd_d = 1'b0;
         err_pn_d  = 1'b0;
         cnt_d     = '0;
      end else if (valid_i) begin
         valid_d   = 1'b1;
         x_rec_d   = x_rec_w;
         s_rec_d   = s_rec_w;
         acc_d     = acc_clamp_w[WIDTH+1:0];
         err_par_d = err_par_q | par_viol_w;
         err_bnd_d = err_bnd_q | bnd_viol_w;
         err_pn_d  = err_pn_q | pn_viol_w;
         if ((par_viol_w || bnd_viol_w || pn_viol_w) && (cnt_q != '1)) begin
            cnt_d = cnt_q + ERR_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         valid_q   <= 1'b0;
         x_rec_q   <= '0;
         s_rec_q   <= '0;
         acc_q     <= '0;
         err_par_q <= 1'b0;
         err_bnd_q <= 1'b0;
         err_pn_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         valid_q   <= valid_d;
         x_rec_q   <= x_rec_d;
         s_rec_q   <= s_rec_d;
         acc_q     <= acc_d;
         err_par_q <= err_par_d;
         err_bnd_q <= err_bnd_d;
         err_pn_q  <= err_pn_d;
         cnt_q     <= cnt_d;
      end
   end

   assign valid_o      = valid_q;
   assign x_rec_o      = x_rec_q;
   assign s_rec_o      = s_rec_q;
   assign acc_o        = acc_q;
   assign err_parity_o = err_par_q;
   assign err_bound_o  = err_bnd_q;
   assign err_pn_o     = err_pn_q;
   assign err_cnt_o    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dem_split_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dem_split_checker: directed vector table plus reset, mid-stream reset |
// | and counter saturation sequences. Rev 1.0                                |
// +--------------------------------------------------------------------------+
module tb_dem_split_checker;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       valid_i;
   logic [4:0] x_out1_i;
   logic [4:0] x_out2_i;
   logic       pn_seq_i;
   logic       clear_i;
   logic       valid_o;
   logic [5:0] x_rec_o;
   logic [5:0] s_rec_o;
   logic [6:0] acc_o;
   logic       err_parity_o;
   logic       err_bound_o;
   logic       err_pn_o;
   logic [7:0] err_cnt_o;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic       v;
      logic       clr;
      logic       pn;
      logic [4:0] x1;
      logic [4:0] x2;
      logic       ev;
      logic [5:0] ex;
      logic [5:0] es;
      logic [6:0] eacc;
      logic       ep;
      logic       eb;
      logic [7:0] ecnt;
   } vec_t;

   vec_t vecs[13];

   dem_split_checker #(.WIDTH(5), .ACC_LIMIT(1), .ERR_CNT_W(8)) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .valid_i      (valid_i),
      .x_out1_i     (x_out1_i),
      .x_out2_i     (x_out2_i),
      .pn_seq_i     (pn_seq_i),
      .clear_i      (clear_i),
      .valid_o      (valid_o),
      .x_rec_o      (x_rec_o),
      .s_rec_o      (s_rec_o),
      .acc_o        (acc_o),
      .err_parity_o (err_parity_o),
      .err_bound_o  (err_bound_o),
      .err_pn_o     (err_pn_o),
      .err_cnt_o    (err_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic ev, input logic [5:0] ex,
                          input logic [5:0] es, input logic [6:0] eacc, input logic ep,
                          input logic eb, input logic [7:0] ecnt);
      chk({tag, ".valid"},  {31'b0, valid_o},      {31'b0, ev});
      chk({tag, ".x_rec"},  {26'b0, x_rec_o},      {26'b0, ex});
      chk({tag, ".s_rec"},  {26'b0, s_rec_o},      {26'b0, es});
      chk({tag, ".acc"},    {25'b0, acc_o},        {25'b0, eacc});
      chk({tag, ".parity"}, {31'b0, err_parity_o}, {31'b0, ep});
      chk({tag, ".bound"},  {31'b0, err_bound_o},  {31'b0, eb});
      chk({tag, ".pn"},     {31'b0, err_pn_o},     32'd0);
      chk({tag, ".cnt"},    {24'b0, err_cnt_o},    {24'b0, ecnt});
   endtask

   task automatic drive(input logic v, input logic clr, input logic [4:0] a,
                        input logic [4:0] b, input logic pn);
      valid_i  = v;
      clear_i  = clr;
      x_out1_i = a;
      x_out2_i = b;
      pn_seq_i = pn;
   endtask

   initial begin
      // v clr pn x1 x2 | ev x s acc par bnd cnt  (pn matches sign where acc was 0)
      vecs[0]  = '{1'b1, 1'b0, 1'b1, 5'd2,  5'd1,  1'b1, 6'd3,  6'h01, 7'h01, 1'b0, 1'b0, 8'd0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 5'd2,  5'd3,  1'b1, 6'd5,  6'h3F, 7'h00, 1'b0, 1'b0, 8'd0};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 5'd3,  5'd1,  1'b1, 6'd4,  6'h02, 7'h01, 1'b1, 1'b1, 8'd1};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 5'd2,  5'd1,  1'b0, 6'd4,  6'h02, 7'h00, 1'b0, 1'b0, 8'd0};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 5'd2,  5'd1,  1'b1, 6'd3,  6'h01, 7'h01, 1'b0, 1'b0, 8'd0};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 5'd3,  5'd2,  1'b1, 6'd5,  6'h01, 7'h01, 1'b0, 1'b1, 8'd1};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 5'd9,  5'd4,  1'b0, 6'd5,  6'h01, 7'h01, 1'b0, 1'b1, 8'd1};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 5'd0,  5'd1,  1'b1, 6'd1,  6'h3F, 7'h00, 1'b0, 1'b1, 8'd1};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  1'b1, 6'd0,  6'h00, 7'h00, 1'b0, 1'b1, 8'd1};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 5'd31, 5'd31, 1'b1, 6'd62, 6'h00, 7'h00, 1'b0, 1'b1, 8'd1};
      vecs[10] = '{1'b1, 1'b0, 1'b1, 5'd31, 5'd0,  1'b1, 6'd31, 6'h1F, 7'h01, 1'b1, 1'b1, 8'd2};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 5'd0,  5'd31, 1'b1, 6'd31, 6'h21, 7'h7F, 1'b1, 1'b1, 8'd3};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 5'd7,  5'd7,  1'b0, 6'd31, 6'h21, 7'h00, 1'b0, 1'b0, 8'd0};

      // Reset held with random inputs
      reset_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         drive(1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
      end
      #1 chk_all("reset", 1'b0, 6'd0, 6'd0, 7'd0, 1'b0, 1'b0, 8'd0);
      @(negedge clk_i);
      reset_i = 1'b0;
      drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
      @(posedge clk_i); #1;
      chk_all("post_reset", 1'b0, 6'd0, 6'd0, 7'd0, 1'b0, 1'b0, 8'd0);

      for (int i = 0; i < 13; i++) begin
         @(negedge clk_i);
         drive(vecs[i].v, vecs[i].clr, vecs[i].x1, vecs[i].x2, vecs[i].pn);
         @(posedge clk_i); #1;
         chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ex, vecs[i].es,
                 vecs[i].eacc, vecs[i].ep, vecs[i].eb, vecs[i].ecnt);
      end

      // Asynchronous reset mid-stream discards the in-flight sample
      @(negedge clk_i);
      drive(1'b1, 1'b0, 5'd2, 5'd1, 1'b1);
      @(posedge clk_i); #1;
      chk("midrst.pre_acc", {25'b0, acc_o}, 32'd1);
      @(negedge clk_i);
      drive(1'b1, 1'b0, 5'd3, 5'd1, 1'b1);
      #1 reset_i = 1'b1;
      #1 chk_all("midrst.async", 1'b0, 6'd0, 6'd0, 7'd0, 1'b0, 1'b0, 8'd0);
      @(negedge clk_i);
      reset_i = 1'b0;
      drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
      @(posedge clk_i); #1;
      chk_all("midrst.after", 1'b0, 6'd0, 6'd0, 7'd0, 1'b0, 1'b0, 8'd0);

      // Counter saturation: (3,1) violates parity and bound every sample
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_i);
         drive(1'b1, 1'b0, 5'd3, 5'd1, 1'b1);
         @(posedge clk_i); #1;
         if (i == 253) chk("sat.cnt254", {24'b0, err_cnt_o}, 32'd254);
         if (i == 254) chk("sat.cnt255", {24'b0, err_cnt_o}, 32'd255);
      end
      chk_all("sat.end", 1'b1, 6'd4, 6'h02, 7'h01, 1'b1, 1'b1, 8'd255);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dem_split_checker.md
Name: dem_split_checker

Overview:
- Receive-side companion of the DEM-DAC tree switching block.
- Takes each split pair (x_out1, x_out2) and rebuilds the original sample x and the switching value s.
- Tracks the first-order mismatch-shaping accumulator (running sum of s) and flags parity and boundedness violations.
- Used as an in-line monitor between a tree node and the unit-element drivers; results are visible in simulation and through status ports.

Parameters:
- WIDTH, 5, width of each split input; matches the switching block's data width.
- ACC_LIMIT, 1, maximum allowed magnitude of the shaping accumulator.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  x_out1_i/x_out2_i hold a sample this cycle.
- x_out1_i  input  WIDTH  upper-branch count, (x+s)/2.
- x_out2_i  input  WIDTH  lower-branch count, (x-s)/2.
- pn_seq_i  input  1  dither bit the switching block used for this sample; used only with the optional feature.
- clear_i  input  1  synchronous clear of accumulator, flags and counter.
- valid_o  output  1  registered; rec outputs are valid.
- x_rec_o  output  WIDTH+1  reconstructed x = x_out1 + x_out2, unsigned.
- s_rec_o  output  WIDTH+1  signed s = x_out1 - x_out2, two's complement.
- acc_o  output  WIDTH+2  signed shaping accumulator after this sample.
- err_parity_o  output  1  sticky parity-rule violation.
- err_bound_o  output  1  sticky accumulator-bound violation.
- err_cnt_o  output  ERR_CNT_W  saturating count of violating samples.

Behaviour:
- Reset (async, reset_i=1): every output and internal register is 0. The accumulator starts at 0.
- Latency: a sample accepted with valid_i=1 at edge N appears on x_rec_o, s_rec_o and acc_o after edge N, with valid_o=1 for exactly one cycle.
- valid_i=0: valid_o=0 next cycle; x_rec_o, s_rec_o and acc_o hold their previous values.
- Arithmetic:
  - Both inputs are zero-extended to WIDTH+1 bits before the add and the subtract.
  - s_rec is computed signed; no overflow is possible at that width.
- Parity rule, checked per sample:
  - x_rec odd requires s_rec in {+1,-1}.
  - x_rec even requires s_rec = 0.
  - Any other combination is a parity violation and sets err_parity_o.
- Accumulator rule:
  - acc_next = acc + s_rec.
  - If |acc_next| > ACC_LIMIT: bound violation, err_bound_o set, and acc is stored clamped to +/-ACC_LIMIT (sign of acc_next).
  - Otherwise acc = acc_next.
  - The accumulator is updated even on a parity-violating sample.
- Error counter:
  - Increments by 1 per sample that has any violation, including multiple violations in the same sample.
  - Saturates at all-ones; no wrap-around.
- Flags: sticky until reset_i or clear_i.
- clear_i=1:
  - Next edge zeroes acc, both flags and err_cnt_o; valid_o=0.
  - A sample arriving in the same cycle is dropped, so clear wins.
  - x_rec_o and s_rec_o hold.
- Reset asserted mid-stream: the in-flight sample is discarded and all state returns to reset values immediately.

Optional Feature:
- Macro DEM_PN_CHECK_EN.
- When defined:
  - Applies to odd samples with acc = 0 before the update.
  - The sign of s_rec must match pn_seq_i (1 -> +1, 0 -> -1).
  - A mismatch sets an extra sticky output err_pn_o and counts toward err_cnt_o.
- When not defined:
  - pn_seq_i is ignored.
  - err_pn_o is still present and tied to 0.

Test Plan:
- Reset: hold reset_i=1 with random inputs -> all outputs 0; release -> still 0 until the first valid sample.
- Odd positive: acc=0, valid with x_out1=2, x_out2=1 -> next cycle valid_o=1, x_rec=3, s_rec=+1, acc=1, no flags.
- Then x_out1=2, x_out2=3 -> x_rec=5, s_rec=-1, acc=0, no flags, err_cnt=0.
- Parity violation: x_out1=3, x_out2=1 -> x_rec=4, s_rec=+2, err_parity_o=1; acc clamps to 1 with err_bound_o=1; err_cnt=1 (single sample counted once).
- Bound violation from acc=0: (2,1) then (3,2) -> second sample acc_next=2, acc_o=1, err_bound_o=1, err_cnt increments by 1.
- Clear collision: clear_i=1 and valid_i=1 with (2,1) -> next cycle valid_o=0, acc=0, flags=0, err_cnt=0. Saturation: force 300 violations with ERR_CNT_W=8 -> err_cnt_o=255.
